// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
// The fetch stage holds imem_req and imem_addr steady until the edge on which imem_ack=1.
interface if_fetch_stage_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 32
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and loads IF/ID.
// A single skid entry parks a fetch that completes while the pipeline is stalled.
module if_fetch_stage #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                PCWrite,
   input  logic                IF_ID_Write,
   input  logic                BranchTaken,
   input  logic [ADDR_W-1:0]   BranchTarget,
   if_fetch_stage_if.master    imem,
   output logic [ADDR_W-1:0]   IF_ID_PC,
   output logic [INSTR_W-1:0]  IF_ID_Instr,
   output logic                IF_ID_Valid
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  skid_pc;
   logic [INSTR_W-1:0] skid_instr;

   logic               advance_c;
   logic               ack_c;
   logic [ADDR_W-1:0]  pc_inc_c;

   // An ack only counts while a request is actually outstanding.
   always_comb begin
      advance_c = PCWrite && IF_ID_Write;
      ack_c     = imem.imem_ack && imem.imem_req;
      pc_inc_c  = pc + ADDR_W'(PC_STEP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_REQ;
         pc             <= RESET_PC;
         imem.imem_req  <= 1'b0;
         imem.imem_addr <= RESET_PC;
         skid_pc        <= '0;
         skid_instr     <= '0;
         IF_ID_PC       <= '0;
         IF_ID_Instr    <= '0;
         IF_ID_Valid    <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (!imem.imem_req) begin
                  // First cycle out of reset: raise the request at the current PC.
                  imem.imem_req <= 1'b1;
                  if (BranchTaken) begin
                     pc             <= BranchTarget;
                     imem.imem_addr <= BranchTarget;
                     IF_ID_Instr    <= '0;
                     IF_ID_Valid    <= 1'b0;
                  end else if (advance_c) begin
                     IF_ID_Instr <= '0;
                     IF_ID_Valid <= 1'b0;
                  end
               end else if (ack_c) begin
                  if (BranchTaken) begin
                     pc             <= BranchTarget;
                     imem.imem_addr <= BranchTarget;
                     IF_ID_Instr    <= '0;
                     IF_ID_Valid    <= 1'b0;
                  end else if (advance_c) begin
                     IF_ID_PC       <= pc;
                     IF_ID_Instr    <= imem.imem_rdata;
                     IF_ID_Valid    <= 1'b1;
                     pc             <= pc_inc_c;
                     imem.imem_addr <= pc_inc_c;
                  end else begin
                     skid_pc       <= pc;
                     skid_instr    <= imem.imem_rdata;
                     imem.imem_req <= 1'b0;
                     state         <= S_HOLD;
                  end
               end else begin
                  if (BranchTaken) begin
                     // Request stays out at the old address; its response is discarded.
                     pc          <= BranchTarget;
                     IF_ID_Instr <= '0;
                     IF_ID_Valid <= 1'b0;
                     state       <= S_DRAIN;
                  end else if (advance_c) begin
                     IF_ID_Instr <= '0;
                     IF_ID_Valid <= 1'b0;
                  end
               end
            end

            S_HOLD: begin
               if (BranchTaken) begin
                  pc             <= BranchTarget;
                  imem.imem_addr <= BranchTarget;
                  imem.imem_req  <= 1'b1;
                  IF_ID_Instr    <= '0;
                  IF_ID_Valid    <= 1'b0;
                  state          <= S_REQ;
               end else if (advance_c) begin
                  IF_ID_PC       <= skid_pc;
                  IF_ID_Instr    <= skid_instr;
                  IF_ID_Valid    <= 1'b1;
                  pc             <= pc_inc_c;
                  imem.imem_addr <= pc_inc_c;
                  imem.imem_req  <= 1'b1;
                  state          <= S_REQ;
               end
            end

            S_DRAIN: begin
               if (BranchTaken) begin
                  pc <= BranchTarget;
               end
               if (BranchTaken || advance_c) begin
                  IF_ID_Instr <= '0;
                  IF_ID_Valid <= 1'b0;
               end
               if (ack_c) begin
                  imem.imem_addr <= BranchTaken ? BranchTarget : pc;
                  state          <= S_REQ;
               end
            end

            default: begin
               state <= S_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: hand-computed IF/ID and imem bus values after each clock edge.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write, ifid_write, br_taken;
   logic [31:0] br_target;
   logic        ack0;
   logic [31:0] ifid_pc0;
   logic [31:0] ifid_instr0;
   logic        ifid_valid0;

   logic        rst1;
   logic        ack1;
   logic [31:0] ifid_pc1;
   logic [31:0] ifid_instr1;
   logic        ifid_valid1;
   logic        one = 1'b1;
   logic        zero = 1'b0;
   logic [31:0] zero32 = '0;

   int vectors = 0;
   int fails   = 0;

   always #5 clk = ~clk;

   if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus0 ();
   if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus1 ();

   // Memory returns the address OR'ed with 0xA000 as the instruction word.
   assign bus0.imem_ack   = ack0;
   assign bus0.imem_rdata = bus0.imem_addr | 32'hA000;
   assign bus1.imem_ack   = ack1;
   assign bus1.imem_rdata = bus1.imem_addr | 32'hA000;

   if_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .PCWrite      (pc_write),
      .IF_ID_Write  (ifid_write),
      .BranchTaken  (br_taken),
      .BranchTarget (br_target),
      .imem         (bus0.master),
      .IF_ID_PC     (ifid_pc0),
      .IF_ID_Instr  (ifid_instr0),
      .IF_ID_Valid  (ifid_valid0)
   );

   if_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
      .clk          (clk),
      .rst          (rst1),
      .PCWrite      (one),
      .IF_ID_Write  (one),
      .BranchTaken  (zero),
      .BranchTarget (zero32),
      .imem         (bus1.master),
      .IF_ID_PC     (ifid_pc1),
      .IF_ID_Instr  (ifid_instr1),
      .IF_ID_Valid  (ifid_valid1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid0(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic valid);
      chk({tag, ".pc"},    ifid_pc0, pc);
      chk({tag, ".instr"}, ifid_instr0, instr);
      chk({tag, ".valid"}, 32'(ifid_valid0), 32'(valid));
   endtask

   task automatic chk_bus0(input string tag, input logic req, input logic [31:0] addr);
      chk({tag, ".req"},  32'(bus0.imem_req), 32'(req));
      chk({tag, ".addr"}, bus0.imem_addr, addr);
   endtask

   initial begin
      rst = 1'b1; rst1 = 1'b1;
      pc_write = 1'b1; ifid_write = 1'b1; br_taken = 1'b0; br_target = '0;
      ack0 = 1'b1; ack1 = 1'b0;

      // Reset with an ack present: ack is ignored, everything at reset values.
      tick();
      chk_bus0("rst", 1'b0, 32'h0);
      chk_ifid0("rst", 32'h0, 32'h0, 1'b0);

      rst = 1'b0; ack0 = 1'b0;
      tick();
      chk_bus0("req_up", 1'b1, 32'h0);
      chk("req_up.valid", 32'(ifid_valid0), 32'h0);

      // Back-to-back fetch, one instruction per cycle.
      ack0 = 1'b1;
      tick();
      chk_ifid0("f0", 32'h0, 32'hA000, 1'b1);
      chk_bus0("f0", 1'b1, 32'h4);
      tick();
      chk_ifid0("f4", 32'h4, 32'hA004, 1'b1);
      chk_bus0("f4", 1'b1, 32'h8);

      // Ack for 0x8 during a 3-cycle stall: parked in skid, IF/ID holds 0x4.
      pc_write = 1'b0; ifid_write = 1'b0;
      tick();
      chk_bus0("stall1", 1'b0, 32'h8);
      chk_ifid0("stall1", 32'h4, 32'hA004, 1'b1);
      tick();
      chk_bus0("stall2", 1'b0, 32'h8);
      chk_ifid0("stall2", 32'h4, 32'hA004, 1'b1);
      tick();
      chk_bus0("stall3", 1'b0, 32'h8);
      chk_ifid0("stall3", 32'h4, 32'hA004, 1'b1);

      pc_write = 1'b1; ifid_write = 1'b1; ack0 = 1'b0;
      tick();
      chk_ifid0("release", 32'h8, 32'hA008, 1'b1);
      chk_bus0("release", 1'b1, 32'hC);
      tick();
      chk("wait.valid", 32'(ifid_valid0), 32'h0);
      chk("wait.instr", ifid_instr0, 32'h0);
      chk_bus0("wait", 1'b1, 32'hC);
      ack0 = 1'b1;
      tick();
      chk_ifid0("fC", 32'hC, 32'hA00C, 1'b1);
      chk_bus0("fC", 1'b1, 32'h10);

      // Redirect to 0x100 while the 0x10 request is outstanding.
      br_taken = 1'b1; br_target = 32'h100; ack0 = 1'b0;
      tick();
      chk("br.valid", 32'(ifid_valid0), 32'h0);
      chk("br.instr", ifid_instr0, 32'h0);
      chk_bus0("br", 1'b1, 32'h10);
      br_taken = 1'b0;
      tick();
      chk_bus0("drain1", 1'b1, 32'h10);
      chk("drain1.valid", 32'(ifid_valid0), 32'h0);
      ack0 = 1'b1;
      tick();
      chk_bus0("drain_ack", 1'b1, 32'h100);
      chk("drain_ack.valid", 32'(ifid_valid0), 32'h0);
      tick();
      chk_ifid0("f100", 32'h100, 32'hA100, 1'b1);
      chk_bus0("f100", 1'b1, 32'h104);

      // Park 0x104 in skid, then branch while still stalled: skid dropped.
      pc_write = 1'b0;
      tick();
      chk_bus0("hold", 1'b0, 32'h104);
      chk_ifid0("hold", 32'h100, 32'hA100, 1'b1);
      br_taken = 1'b1; br_target = 32'h200;
      tick();
      chk_bus0("hold_br", 1'b1, 32'h200);
      chk("hold_br.valid", 32'(ifid_valid0), 32'h0);
      chk("hold_br.instr", ifid_instr0, 32'h0);
      br_taken = 1'b0; pc_write = 1'b1;
      tick();
      chk_ifid0("f200", 32'h200, 32'hA200, 1'b1);
      chk_bus0("f200", 1'b1, 32'h204);

      // Reset asserted mid-handshake with ack high.
      rst = 1'b1;
      tick();
      chk_bus0("midrst", 1'b0, 32'h0);
      chk_ifid0("midrst", 32'h0, 32'h0, 1'b0);
      rst = 1'b0; ack0 = 1'b0;
      tick();
      chk_bus0("midrst_up", 1'b1, 32'h0);

      // PC wrap from 0xFFFF_FFF8 on the second instance.
      rst1 = 1'b1;
      tick();
      chk("wrap_rst.req", 32'(bus1.imem_req), 32'h0);
      chk("wrap_rst.addr", bus1.imem_addr, 32'hFFFF_FFF8);
      rst1 = 1'b0;
      tick();
      chk("wrap_up.req", 32'(bus1.imem_req), 32'h1);
      ack1 = 1'b1;
      tick();
      chk("wrap0.pc", ifid_pc1, 32'hFFFF_FFF8);
      chk("wrap0.valid", 32'(ifid_valid1), 32'h1);
      chk("wrap0.addr", bus1.imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap1.pc", ifid_pc1, 32'hFFFF_FFFC);
      chk("wrap1.addr", bus1.imem_addr, 32'h0000_0000);
      tick();
      chk("wrap2.pc", ifid_pc1, 32'h0000_0000);
      chk("wrap2.instr", ifid_instr1, 32'h0000_A000);
      chk("wrap2.valid", 32'(ifid_valid1), 32'h1);
      ack1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
